// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch redirect controller: data word, redirect FSM states,
// and the drain-counter reload helper.
package branch_redirect_ctrl_pkg;

  typedef logic        u1;
  typedef logic [63:0] word_t;

  localparam int DRAIN_CNT_W = 4;

  typedef enum logic [1:0] {
    RDR_IDLE,
    RDR_REDIRECT,
    RDR_DRAIN
  } redirect_state_t;

  // Counter reload on accept; a zero-length window never enters DRAIN.
  function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int drain_cycles);
    if (drain_cycles <= 0) return '0;
    return DRAIN_CNT_W'(drain_cycles - 1);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_stats.sv
// Saturating statistics counter pair for the redirect controller
// (taken branches seen in IDLE, cycles stalled waiting for fetch accept).
module branch_redirect_ctrl_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_inc_branch,
  input  logic             i_inc_stall,
  output logic [CNT_W-1:0] o_branches,
  output logic [CNT_W-1:0] o_stall_cyc
);

  logic [CNT_W-1:0] r_branches;
  logic [CNT_W-1:0] r_stall_cyc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_branches  <= '0;
      r_stall_cyc <= '0;
    end else begin
      if (i_inc_branch && (r_branches != '1))
        r_branches <= r_branches + CNT_W'(1);
      if (i_inc_stall && (r_stall_cyc != '1))
        r_stall_cyc <= r_stall_cyc + CNT_W'(1);
    end
  end

  assign o_branches  = r_branches;
  assign o_stall_cyc = r_stall_cyc;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a taken branch from EX into IF/ID flushes, a registered redirect-PC handshake
// to fetch and a post-accept drain window. REDIRECT_STATS_EN adds statistics counters.
//
//   state        | meaning
//   RDR_IDLE     | no redirect in flight; take acted on here
//   RDR_REDIRECT | redirect_pc offered to fetch, waiting for redirect_ready
//   RDR_DRAIN    | accepted; flush_if held to discard stale fetch responses
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_branch_enable,
  input  logic [63:0]       ex_target,
  output logic              redirect_valid,
  output logic [63:0]       redirect_pc,
  input  logic              redirect_ready,
  output logic              flush_if,
  output logic              flush_id,
  output logic              busy
`ifdef REDIRECT_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_stall_cyc
`endif
);

  redirect_state_t         r_state;
  redirect_state_t         w_state_nxt;
  logic [DRAIN_CNT_W-1:0]  r_drain_cnt;
  logic [DRAIN_CNT_W-1:0]  w_drain_cnt_nxt;
  logic [63:0]             r_redirect_pc;
  logic                    r_redirect_valid;
  logic                    w_take;
  logic                    w_latch_pc;

  assign w_take = ex_valid & ex_branch_enable & ~ex_stall;

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_latch_pc      = 1'b0;
    flush_if        = 1'b0;
    flush_id        = 1'b0;
    case (r_state)
      RDR_IDLE: begin
        if (w_take) begin
          flush_if    = 1'b1;
          flush_id    = 1'b1;
          w_latch_pc  = 1'b1;
          w_state_nxt = RDR_REDIRECT;
        end
      end
      RDR_REDIRECT: begin
        flush_if = 1'b1;
        if (redirect_ready) begin
          if (DRAIN_CYCLES == 0) begin
            w_state_nxt = RDR_IDLE;
          end else begin
            w_state_nxt     = RDR_DRAIN;
            w_drain_cnt_nxt = drain_load(DRAIN_CYCLES);
          end
        end
      end
      RDR_DRAIN: begin
        flush_if = 1'b1;
        if (r_drain_cnt == '0)
          w_state_nxt = RDR_IDLE;
        else
          w_drain_cnt_nxt = r_drain_cnt - DRAIN_CNT_W'(1);
      end
      default: begin
        w_state_nxt     = RDR_IDLE;
        w_drain_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= RDR_IDLE;
      r_drain_cnt      <= '0;
      r_redirect_pc    <= '0;
      r_redirect_valid <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_drain_cnt      <= w_drain_cnt_nxt;
      r_redirect_valid <= (w_state_nxt == RDR_REDIRECT);
      if (w_latch_pc)
        r_redirect_pc <= ex_target;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign busy           = (r_state != RDR_IDLE);

`ifdef REDIRECT_STATS_EN
  logic w_inc_branch;
  logic w_inc_stall;

  assign w_inc_branch = w_take & (r_state == RDR_IDLE);
  assign w_inc_stall  = (r_state == RDR_REDIRECT) & ~redirect_ready;

  branch_redirect_ctrl_stats #(
    .CNT_W (CNT_W)
  ) u_redirect_stats (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_inc_branch (w_inc_branch),
    .i_inc_stall  (w_inc_stall),
    .o_branches   (stat_branches),
    .o_stall_cyc  (stat_stall_cyc)
  );
`endif

`ifndef SYNTHESIS
  // Flushing keeps wrong-path work out of EX, so a take while busy is a front-end bug.
  a_no_take_busy: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_take && (r_state != RDR_IDLE)));
  a_cfg: assert property (@(posedge clk)
    (DRAIN_CYCLES >= 0) && (DRAIN_CYCLES <= 15) && (CNT_W > 0));
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: three instances (drain 1, 0, 3) share one
// stimulus stream; expected per-cycle outputs come from a window-based timeline model.
module tb_branch_redirect_ctrl;

  localparam int NCYC = 1500;
  localparam int NDUT = 3;

  typedef struct packed {
    logic        fi;
    logic        fid;
    logic        rv;
    logic        bz;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_stall = 1'b0;
  logic        ex_branch_enable = 1'b0;
  logic [63:0] ex_target = '0;
  logic        redirect_ready = 1'b0;

  logic        rv  [NDUT];
  logic [63:0] rpc [NDUT];
  logic        fi  [NDUT];
  logic        fid [NDUT];
  logic        bz  [NDUT];
`ifdef REDIRECT_STATS_EN
  logic [31:0] st_br [NDUT];
  logic [31:0] st_st [NDUT];
`endif

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.DRAIN_CYCLES(1)) u_dut_d1 (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_branch_enable(ex_branch_enable), .ex_target(ex_target),
    .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .redirect_ready(redirect_ready),
    .flush_if(fi[0]), .flush_id(fid[0]), .busy(bz[0])
`ifdef REDIRECT_STATS_EN
    , .stat_branches(st_br[0]), .stat_stall_cyc(st_st[0])
`endif
  );

  branch_redirect_ctrl #(.DRAIN_CYCLES(0)) u_dut_d0 (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_branch_enable(ex_branch_enable), .ex_target(ex_target),
    .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .redirect_ready(redirect_ready),
    .flush_if(fi[1]), .flush_id(fid[1]), .busy(bz[1])
`ifdef REDIRECT_STATS_EN
    , .stat_branches(st_br[1]), .stat_stall_cyc(st_st[1])
`endif
  );

  branch_redirect_ctrl #(.DRAIN_CYCLES(3)) u_dut_d3 (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_branch_enable(ex_branch_enable), .ex_target(ex_target),
    .redirect_valid(rv[2]), .redirect_pc(rpc[2]), .redirect_ready(redirect_ready),
    .flush_if(fi[2]), .flush_id(fid[2]), .busy(bz[2])
`ifdef REDIRECT_STATS_EN
    , .stat_branches(st_br[2]), .stat_stall_cyc(st_st[2])
`endif
  );

  function automatic int drain_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Stimulus tables and expected timeline
  bit          a_rst  [NCYC];
  bit          a_val  [NCYC];
  bit          a_en   [NCYC];
  bit          a_stl  [NCYC];
  bit          a_rdy  [NCYC];
  bit          a_take [NCYC];
  logic [63:0] a_tgt  [NCYC];
  exp_t        e_arr  [NDUT][NCYC];

  exp_t sb_q[$];
  int   cyc_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int c, input int d,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %h expected %h", name, d, c, act, exp);
    end
  endtask

  task automatic build_model();
    int   busy_end [NDUT];
    logic [63:0] pc_m [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      busy_end[d] = -1;
      pc_m[d]     = '0;
      for (int k = 0; k < NCYC; k++) e_arr[d][k] = '0;
    end
    for (int c = 0; c < NCYC; c++) begin
      bit all_idle;
      bit want;
      a_take[c] = 1'b0;
      if (!a_rst[c]) begin
        a_en[c] = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
          for (int k = c; k <= busy_end[d] && k < NCYC; k++) e_arr[d][k] = '0;
          busy_end[d] = c - 1;
          pc_m[d]     = '0;
        end
      end
      for (int d = 0; d < NDUT; d++) e_arr[d][c].pc = pc_m[d];
      all_idle = 1'b1;
      for (int d = 0; d < NDUT; d++) if (busy_end[d] >= c) all_idle = 1'b0;
      want = a_rst[c] && a_val[c] && a_en[c] && !a_stl[c];
      if (want && !all_idle) begin
        a_en[c] = 1'b0;
        want    = 1'b0;
      end
      if (want) begin
        int acc;
        a_take[c] = 1'b1;
        acc = c + 1;
        while (acc < NCYC && !a_rdy[acc]) acc++;
        for (int d = 0; d < NDUT; d++) begin
          e_arr[d][c].fi  = 1'b1;
          e_arr[d][c].fid = 1'b1;
          for (int k = c + 1; k <= acc && k < NCYC; k++) begin
            e_arr[d][k].rv = 1'b1;
            e_arr[d][k].fi = 1'b1;
            e_arr[d][k].bz = 1'b1;
          end
          for (int k = acc + 1; k <= acc + drain_of(d) && k < NCYC; k++) begin
            e_arr[d][k].fi = 1'b1;
            e_arr[d][k].bz = 1'b1;
          end
          busy_end[d] = acc + drain_of(d);
          pc_m[d]     = a_tgt[c];
        end
      end
    end
  endtask

  task automatic build_stimulus();
    for (int c = 0; c < NCYC; c++) begin
      if (c < 80) begin
        a_rst[c] = 1'b1; a_val[c] = 1'b0; a_en[c] = 1'b0; a_stl[c] = 1'b0;
        a_rdy[c] = 1'b1; a_tgt[c] = 64'h0;
      end else begin
        a_rst[c] = ($urandom_range(0, 199) != 0);
        a_val[c] = $urandom_range(0, 1) == 1;
        a_en[c]  = $urandom_range(0, 9) < 4;
        a_stl[c] = $urandom_range(0, 3) == 0;
        a_rdy[c] = $urandom_range(0, 9) < 6;
        a_tgt[c] = {$urandom, $urandom};
      end
    end
    for (int c = 0; c < 3; c++) a_rst[c] = 1'b0;
    // taken branch with fetch always ready
    a_val[5] = 1'b1; a_en[5] = 1'b1; a_tgt[5] = 64'h0000_0000_8000_0040;
    // backpressure for three cycles, accept on the fourth
    a_val[15] = 1'b1; a_en[15] = 1'b1; a_tgt[15] = 64'h0000_0000_1234_5678;
    for (int c = 16; c <= 18; c++) a_rdy[c] = 1'b0;
    // stalled take held for two cycles
    for (int c = 30; c <= 32; c++) begin
      a_val[c] = 1'b1; a_en[c] = 1'b1; a_stl[c] = (c < 32);
    end
    a_tgt[30] = 64'h1111_0000_0000_0030;
    a_tgt[31] = 64'h2222_0000_0000_0031;
    a_tgt[32] = 64'hdead_beef_0000_1000;
    // reset dropped while a redirect waits for fetch
    a_val[45] = 1'b1; a_en[45] = 1'b1; a_tgt[45] = 64'hcafe_0000_0000_0080;
    for (int c = 46; c <= 49; c++) a_rdy[c] = 1'b0;
    a_rst[47] = 1'b0;
    // not-taken stream
    for (int c = 60; c <= 69; c++) begin
      a_val[c] = 1'b1; a_en[c] = 1'b0; a_tgt[c] = 64'h4444_0000_0000_0000 + 64'(c);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        int c;
        c = cyc_q.pop_front();
        for (int d = 0; d < NDUT; d++) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("flush_if",       c, d, 64'(fi[d]),  64'(e.fi));
          chk("flush_id",       c, d, 64'(fid[d]), 64'(e.fid));
          chk("redirect_valid", c, d, 64'(rv[d]),  64'(e.rv));
          chk("busy",           c, d, 64'(bz[d]),  64'(e.bz));
          chk("redirect_pc",    c, d, rpc[d],      e.pc);
        end
      end
    end
  end

  initial begin : driver
    build_stimulus();
    build_model();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      reset_n          = a_rst[c];
      ex_valid         = a_val[c];
      ex_branch_enable = a_en[c];
      ex_stall         = a_stl[c];
      ex_target        = a_tgt[c];
      redirect_ready   = a_rdy[c];
      for (int d = 0; d < NDUT; d++) sb_q.push_back(e_arr[d][c]);
      cyc_q.push_back(c);
    end
    @(posedge clk);
    #1;
    ex_valid         = 1'b0;
    ex_branch_enable = 1'b0;
    ex_stall         = 1'b0;
    redirect_ready   = 1'b1;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", NCYC, 0, 64'(sb_q.size()), 64'd0);
`ifdef REDIRECT_STATS_EN
    for (int d = 0; d < NDUT; d++) begin
      longint br_m;
      longint st_m;
      br_m = 0;
      st_m = 0;
      for (int c = 0; c < NCYC; c++) begin
        if (!a_rst[c]) begin
          br_m = 0;
          st_m = 0;
        end else begin
          if (a_take[c]) br_m++;
          if (e_arr[d][c].rv && !a_rdy[c]) st_m++;
        end
      end
      chk("stat_branches",  NCYC, d, 64'(st_br[d]), 64'(br_m));
      chk("stat_stall_cyc", NCYC, d, 64'(st_st[d]), 64'(st_m));
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
